// File: rtl/fsm_detect_sched.sv
// rtl/fsm_detect_sched.sv - round-robin scheduler sharing one serial "101" detector; optional FSM_SCHED_CARRY_EN
module fsm_detect_sched #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int HW = $clog2(W + 1),
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IW-1:0]  rsp_id,
    output logic [HW-1:0]  rsp_hits
);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} ctl_t;
    typedef enum logic [1:0] {DA, DB, DC, DD} det_t;

    ctl_t          ctl_q, ctl_d;
    det_t          det_q, det_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] rr_q, rr_d;
`ifdef FSM_SCHED_CARRY_EN
    det_t          saved_q [N];
    det_t          saved_d [N];
`endif

    logic          found_c;
    logic [IW-1:0] win_c;
    logic [IW-1:0] cand_c;
    logic [W-1:0]  win_word_c;
    logic          accept_c;
    det_t          det_nx_c;

    // Moore "101" detector transition; entering DD is a hit
    function automatic det_t det_next(input det_t s, input logic b);
        case (s)
            DA:      return b ? DB : DA;
            DB:      return b ? DB : DC;
            DC:      return b ? DD : DA;
            default: return b ? DB : DC;
        endcase
    endfunction

    // Round-robin search starting at rr_q, wrapping modulo N
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int k = 0; k < N; k++) begin
            cand_c = IW'((int'(rr_q) + k) % N);
            if (!found_c && req_valid[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    // Select the winning requester's word
    always_comb begin
        win_word_c = '0;
        for (int k = 0; k < N; k++) begin
            if (win_c == IW'(k)) begin
                win_word_c = req_data[k*W +: W];
            end
        end
    end

    // One-hot grant, only in IDLE and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (!reset && ctl_q == IDLE && found_c) begin
            req_ready[win_c] = 1'b1;
        end
    end

    assign accept_c  = |(req_valid & req_ready);
    assign det_nx_c  = det_next(det_q, sreg_q[W-1]);
    assign rsp_valid = (ctl_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_hits  = hits_q;

    // Controller next state: accept, serialize MSB-first, then hold the response
    always_comb begin
        ctl_d  = ctl_q;
        det_d  = det_q;
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        hits_d = hits_q;
        id_d   = id_q;
        rr_d   = rr_q;
`ifdef FSM_SCHED_CARRY_EN
        saved_d = saved_q;
`endif
        case (ctl_q)
            IDLE: begin
                if (accept_c) begin
                    sreg_d = win_word_c;
                    cnt_d  = HW'(W);
                    hits_d = '0;
`ifdef FSM_SCHED_CARRY_EN
                    det_d  = saved_q[win_c];
`else
                    det_d  = DA;
`endif
                    id_d   = win_c;
                    rr_d   = (win_c == IW'(N - 1)) ? '0 : win_c + IW'(1);
                    ctl_d  = SHIFT;
                end
            end
            SHIFT: begin
                det_d  = det_nx_c;
                sreg_d = {sreg_q[W-2:0], 1'b0};
                cnt_d  = cnt_q - HW'(1);
                if (det_nx_c == DD) begin
                    hits_d = hits_q + HW'(1);
                end
                if (cnt_q == HW'(1)) begin
                    ctl_d = RESP;
`ifdef FSM_SCHED_CARRY_EN
                    saved_d[id_q] = det_nx_c;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ctl_d = IDLE;
                end
            end
            default: ctl_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q  <= IDLE;
            det_q  <= DA;
            sreg_q <= '0;
            cnt_q  <= '0;
            hits_q <= '0;
            id_q   <= '0;
            rr_q   <= '0;
`ifdef FSM_SCHED_CARRY_EN
            for (int k = 0; k < N; k++) begin
                saved_q[k] <= DA;
            end
`endif
        end else begin
            ctl_q  <= ctl_d;
            det_q  <= det_d;
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            hits_q <= hits_d;
            id_q   <= id_d;
            rr_q   <= rr_d;
`ifdef FSM_SCHED_CARRY_EN
            saved_q <= saved_d;
`endif
        end
    end

endmodule
